// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS 8b/10b encoder: control tokens, HDMI
// guard-band words and the running-disparity counter width.
package tmds_pkg;

    // Running disparity counter width; |cnt| never exceeds 10.
    localparam int CNT_W = 5;

    // DVI control tokens, indexed by {c1, c0}. Bit 0 is transmitted first.
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    // HDMI video guard-band words (channels 0 and 2 share one word).
    localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

    // Map the two control bits to their token.
    function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
        logic [9:0] tok;
        case ({c1, c0})
            2'b00:   tok = CTRL_TOKEN_00;
            2'b01:   tok = CTRL_TOKEN_01;
            2'b10:   tok = CTRL_TOKEN_10;
            default: tok = CTRL_TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Combinational ones counter for an 8-bit word (result 0..8).
module tmds_popcount8 (
    input  logic [7:0] d_i,
    output logic [3:0] cnt_o
);

    // Sum the individual bits.
    always_comb begin
        cnt_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + {3'b000, d_i[i]};
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// Single-channel TMDS 8b/10b encoder, three-stage pipeline, one symbol per
// clock, fixed 3-cycle latency for both data and control. There is no
// handshake: a new input is taken every clock and a symbol leaves every clock.
// Optional HDMI guard band before each DE rise: define TMDS_ENC_GUARD_EN.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dv_i,
    input  logic       c0_i,
    input  logic       c1_i,
    input  logic [7:0] d_i,
    output logic [9:0] q_o
);

    localparam logic [9:0]       GUARD_WORD = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_EIGHT  = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    // ---------------- stage 1: input register + popcount ----------------
    logic       s1_dv_q;
    logic [1:0] s1_c_q;
    logic [7:0] s1_d_q;
    logic [3:0] n1d;

    // Capture the raw pixel/control inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_dv_q <= 1'b0;
            s1_c_q  <= 2'b00;
            s1_d_q  <= 8'h00;
        end else begin
            s1_dv_q <= dv_i;
            s1_c_q  <= {c1_i, c0_i};
            s1_d_q  <= d_i;
        end
    end

    tmds_popcount8 u_pop_d (
        .d_i   (s1_d_q),
        .cnt_o (n1d)
    );

    // ---------------- stage 2: transition minimisation ----------------
    logic       use_xnor;
    logic [8:0] qm_d;
    logic [3:0] n1q_d;

    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !s1_d_q[0]);

    // Chain XOR/XNOR across the byte; bit 8 records which one was used.
    always_comb begin
        qm_d    = 9'd0;
        qm_d[0] = s1_d_q[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ s1_d_q[i]) : (qm_d[i-1] ^ s1_d_q[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    tmds_popcount8 u_pop_qm (
        .d_i   (qm_d[7:0]),
        .cnt_o (n1q_d)
    );

    logic       s2_dv_q;
    logic [1:0] s2_c_q;
    logic [8:0] s2_qm_q;
    logic [3:0] s2_n1_q;

    // Register the intermediate word and its ones count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_dv_q <= 1'b0;
            s2_c_q  <= 2'b00;
            s2_qm_q <= 9'd0;
            s2_n1_q <= 4'd0;
        end else begin
            s2_dv_q <= s1_dv_q;
            s2_c_q  <= s1_c_q;
            s2_qm_q <= qm_d;
            s2_n1_q <= n1q_d;
        end
    end

    // ---------------- stage 3: DC balance / control / guard ----------------
    logic [9:0]       q_q;
    logic [9:0]       q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] n1_w;
    logic [CNT_W-1:0] diff;     // n1q - n0q, two's complement
    logic             cnt_pos;
    logic             cnt_neg;
    logic             qm8;
    logic             guard_active;

    assign qm8     = s2_qm_q[8];
    assign n1_w    = CNT_W'(s2_n1_q);
    assign diff    = n1_w + n1_w - CNT_EIGHT;
    assign cnt_neg = cnt_q[CNT_W-1];
    assign cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != CNT_ZERO);

`ifdef TMDS_ENC_GUARD_EN
    // Blank symbol with DE arriving within the next two symbols.
    assign guard_active = !s2_dv_q && (s1_dv_q || dv_i);
`else
    assign guard_active = 1'b0;
`endif

    // Choose the output symbol and the next running disparity.
    always_comb begin
        q_d   = ctrl_token(s2_c_q[1], s2_c_q[0]);
        cnt_d = CNT_ZERO;
        if (s2_dv_q) begin
            if ((cnt_q == CNT_ZERO) || (s2_n1_q == 4'd4)) begin
                q_d   = {~qm8, qm8, qm8 ? s2_qm_q[7:0] : ~s2_qm_q[7:0]};
                cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
            end else if ((cnt_pos && (s2_n1_q > 4'd4)) || (cnt_neg && (s2_n1_q < 4'd4))) begin
                q_d   = {1'b1, qm8, ~s2_qm_q[7:0]};
                cnt_d = cnt_q + (qm8 ? CNT_TWO : CNT_ZERO) - diff;
            end else begin
                q_d   = {1'b0, qm8, s2_qm_q[7:0]};
                cnt_d = cnt_q - (qm8 ? CNT_ZERO : CNT_TWO) + diff;
            end
        end else if (guard_active) begin
            q_d = GUARD_WORD;
        end
    end

    // Output symbol and disparity registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= CTRL_TOKEN_00;
            cnt_q <= CNT_ZERO;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Testbench for tmds_encoder (CHANNEL = 1). Guard-band expectations follow
// TMDS_ENC_GUARD_EN when it is defined for the build.
module tb_tmds_encoder;

`ifdef TMDS_ENC_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       dv_i = 1'b0;
    logic       c0_i = 1'b0;
    logic       c1_i = 1'b0;
    logic [7:0] d_i  = 8'h00;
    logic [9:0] q_o;

    tmds_encoder #(.CHANNEL(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .dv_i (dv_i),
        .c0_i (c0_i),
        .c1_i (c1_i),
        .d_i  (d_i),
        .q_o  (q_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q[$];
    logic [4:0] expc_q[$];
    logic [7:0] expd_q[$];
    logic       expdv_q[$];
    int         due_q[$];

    logic [9:0] qlog[int];
    logic [4:0] clog[int];

    // Reference model state and the two inputs not yet resolved (the guard
    // band needs two inputs of lookahead).
    int         m_cnt = 0;
    logic       h1_dv = 1'b0, h2_dv = 1'b0;
    logic [1:0] h1_c  = 2'b00, h2_c = 2'b00;
    logic [7:0] h1_d  = 8'h00, h2_d = 8'h00;

    function automatic logic [9:0] model_enc(input logic dv, input logic [1:0] c,
                                             input logic [7:0] d, input logic la);
        int         n1;
        int         n1q;
        int         diff;
        logic       use_x;
        logic [8:0] qm;
        logic [9:0] q;
        if (!dv) begin
            m_cnt = 0;
            if (la && GUARD_ON) return 10'b0100110011;
            case (c)
                2'b00:   return 10'b1101010100;
                2'b01:   return 10'b0010101011;
                2'b10:   return 10'b0101010100;
                default: return 10'b1010101011;
            endcase
        end
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(d[i]);
        use_x = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm    = 9'd0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_x;
        n1q = 0;
        for (int i = 0; i < 8; i++) n1q += int'(qm[i]);
        diff = n1q - (8 - n1q);
        if (m_cnt == 0 || diff == 0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_cnt += qm[8] ? diff : -diff;
        end else if ((m_cnt > 0 && diff > 0) || (m_cnt < 0 && diff < 0)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            m_cnt += (qm[8] ? 2 : 0) - diff;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            m_cnt += (qm[8] ? 0 : -2) + diff;
        end
        return q;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] q);
        logic [7:0] w;
        logic [7:0] r;
        w = q[9] ? ~q[7:0] : q[7:0];
        r[0] = w[0];
        for (int i = 1; i < 8; i++) r[i] = q[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return r;
    endfunction

    // ---------------- monitor: compare on the falling edge ----------------
    initial begin
        logic [9:0] e;
        logic [4:0] ec;
        logic [7:0] ed;
        logic       edv;
        forever begin
            @(negedge clk);
            if (!rst) begin
                qlog[cyc] = q_o;
                clog[cyc] = dut.cnt_q;
                checks++;
                if ($signed(dut.cnt_q) > 10 || $signed(dut.cnt_q) < -10) begin
                    errors++;
                    $display("FAIL cnt_bound cyc=%0d got=%0d limit=+-10", cyc, $signed(dut.cnt_q));
                end
                while (due_q.size() > 0 && due_q[0] < cyc) begin
                    errors++;
                    $display("FAIL missed_symbol cyc=%0d due=%0d exp=%h", cyc, due_q[0], exp_q[0]);
                    void'(due_q.pop_front()); void'(exp_q.pop_front());
                    void'(expc_q.pop_front()); void'(expd_q.pop_front()); void'(expdv_q.pop_front());
                end
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    void'(due_q.pop_front());
                    e = exp_q.pop_front(); ec = expc_q.pop_front();
                    ed = expd_q.pop_front(); edv = expdv_q.pop_front();
                    checks++;
                    if (q_o !== e) begin
                        errors++;
                        $display("FAIL q_o cyc=%0d got=%h exp=%h", cyc, q_o, e);
                    end
                    checks++;
                    if (dut.cnt_q !== ec) begin
                        errors++;
                        $display("FAIL cnt cyc=%0d got=%0d exp=%0d", cyc, $signed(dut.cnt_q), $signed(ec));
                    end
                    if (edv) begin
                        checks++;
                        if (decode(q_o) !== ed) begin
                            errors++;
                            $display("FAIL decode cyc=%0d got=%h exp=%h", cyc, decode(q_o), ed);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Apply one input for one clock; resolve the input from two clocks ago.
    task automatic drive(input logic dv, input logic [1:0] c, input logic [7:0] d);
        logic [9:0] e;
        dv_i = dv; c1_i = c[1]; c0_i = c[0]; d_i = d;
        e = model_enc(h2_dv, h2_c, h2_d, h1_dv || dv);
        exp_q.push_back(e);
        expc_q.push_back(m_cnt[4:0]);
        expd_q.push_back(h2_d);
        expdv_q.push_back(h2_dv);
        due_q.push_back(cyc + 1);
        h2_dv = h1_dv; h2_c = h1_c; h2_d = h1_d;
        h1_dv = dv;    h1_c = c;    h1_d = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 8'h00);
    endtask

    task automatic clear_model();
        exp_q.delete(); expc_q.delete(); expd_q.delete(); expdv_q.delete(); due_q.delete();
        m_cnt = 0;
        h1_dv = 1'b0; h1_c = 2'b00; h1_d = 8'h00;
        h2_dv = 1'b0; h2_c = 2'b00; h2_d = 8'h00;
        dv_i = 1'b0; c1_i = 1'b0; c0_i = 1'b0; d_i = 8'h00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (q_o !== 10'h354) begin
                errors++;
                $display("FAIL reset_q got=%h exp=354", q_o);
            end
        end
        checks++;
        if (dut.cnt_q !== 5'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d exp=0", dut.cnt_q);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        idle(4);
        begin
            int t0;
            t0 = cyc;
            drive(1'b0, 2'b01, 8'h00);
            idle(4);
            checks++;
            if (!qlog.exists(t0 + 2) || qlog[t0 + 2] !== 10'h354) begin
                errors++;
                $display("FAIL latency_early got=%h exp=354", qlog.exists(t0 + 2) ? qlog[t0 + 2] : 10'hx);
            end
            checks++;
            if (!qlog.exists(t0 + 3) || qlog[t0 + 3] !== 10'h0AB) begin
                errors++;
                $display("FAIL latency_3clk got=%h exp=0ab", qlog.exists(t0 + 3) ? qlog[t0 + 3] : 10'hx);
            end
        end
    endtask

    task automatic test_control_tokens();
        logic [9:0] tok[4];
        int t0;
        tok[0] = 10'h354; tok[1] = 10'h0AB; tok[2] = 10'h154; tok[3] = 10'h2AB;
        idle(2);
        t0 = cyc;
        for (int i = 0; i < 4; i++) drive(1'b0, 2'(i), 8'($urandom_range(0, 255)));
        idle(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!qlog.exists(t0 + 3 + i) || qlog[t0 + 3 + i] !== tok[i]) begin
                errors++;
                $display("FAIL ctrl_token%0d got=%h exp=%h", i,
                         qlog.exists(t0 + 3 + i) ? qlog[t0 + 3 + i] : 10'hx, tok[i]);
            end
        end
    endtask

    task automatic test_zero_stream();
        logic [9:0] eq[5];
        logic [4:0] ec[5];
        int t0;
        eq[0] = 10'h100; eq[1] = 10'h3FF; eq[2] = 10'h100; eq[3] = 10'h3FF; eq[4] = 10'h100;
        ec[0] = 5'b11000; ec[1] = 5'd2; ec[2] = 5'b11010; ec[3] = 5'd4; ec[4] = 5'b11100;
        idle(3);
        t0 = cyc;
        for (int i = 0; i < 5; i++) drive(1'b1, 2'b00, 8'h00);
        idle(4);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!qlog.exists(t0 + 3 + i) || qlog[t0 + 3 + i] !== eq[i] || clog[t0 + 3 + i] !== ec[i]) begin
                errors++;
                $display("FAIL zero_stream%0d got=%h/%0d exp=%h/%0d", i,
                         qlog.exists(t0 + 3 + i) ? qlog[t0 + 3 + i] : 10'hx,
                         qlog.exists(t0 + 3 + i) ? $signed(clog[t0 + 3 + i]) : 0, eq[i], $signed(ec[i]));
            end
        end
        checks++;
        if (!qlog.exists(t0 + 8) || qlog[t0 + 8] !== 10'h354 || clog[t0 + 8] !== 5'd0) begin
            errors++;
            $display("FAIL zero_stream_end got=%h exp=354 with cnt 0",
                     qlog.exists(t0 + 8) ? qlog[t0 + 8] : 10'hx);
        end
    endtask

    task automatic test_single_symbol();
        int t0;
        idle(3);
        t0 = cyc;
        drive(1'b1, 2'b00, 8'hFF);
        idle(4);
        checks++;
        if (!qlog.exists(t0 + 3) || qlog[t0 + 3] !== 10'h200) begin
            errors++;
            $display("FAIL single_ff got=%h exp=200", qlog.exists(t0 + 3) ? qlog[t0 + 3] : 10'hx);
        end
        checks++;
        if (!qlog.exists(t0 + 4) || qlog[t0 + 4] !== 10'h354 || clog[t0 + 4] !== 5'd0) begin
            errors++;
            $display("FAIL single_ff_blank got=%h exp=354 with cnt 0",
                     qlog.exists(t0 + 4) ? qlog[t0 + 4] : 10'hx);
        end
    endtask

    task automatic test_guard();
        logic [9:0] g;
        int t0;
        g = GUARD_ON ? 10'h133 : 10'h354;
        idle(3);
        t0 = cyc;
        idle(4);
        drive(1'b1, 2'b00, 8'h55);
        drive(1'b1, 2'b00, 8'hA3);
        idle(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!qlog.exists(t0 + 3 + i) || qlog[t0 + 3 + i] !== ((i >= 2) ? g : 10'h354)) begin
                errors++;
                $display("FAIL guard_pos%0d got=%h exp=%h", i,
                         qlog.exists(t0 + 3 + i) ? qlog[t0 + 3 + i] : 10'hx, (i >= 2) ? g : 10'h354);
            end
        end
    endtask

    task automatic test_pulses();
        idle(3);
        drive(1'b1, 2'b00, 8'h3C);
        drive(1'b0, 2'b10, 8'h00);
        drive(1'b1, 2'b00, 8'hE1);
        drive(1'b1, 2'b00, 8'h07);
        drive(1'b0, 2'b01, 8'h00);
        drive(1'b0, 2'b01, 8'h00);
        drive(1'b1, 2'b00, 8'h10);
        idle(5);
    endtask

    task automatic test_mid_reset();
        idle(2);
        for (int i = 0; i < 6; i++) drive(1'b1, 2'b00, 8'($urandom_range(0, 255)));
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (q_o !== 10'h354) begin
            errors++;
            $display("FAIL midreset_q got=%h exp=354", q_o);
        end
        checks++;
        if (dut.cnt_q !== 5'd0) begin
            errors++;
            $display("FAIL midreset_cnt got=%0d exp=0", $signed(dut.cnt_q));
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b00, 8'($urandom_range(0, 255)));
        idle(4);
    endtask

    task automatic test_random();
        int n;
        int len;
        n = 0;
        while (n < 10000) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) drive(1'b1, 2'b00, 8'($urandom_range(0, 255)));
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) drive(1'b0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            n += 1;
            n += len + 10;
        end
        idle(4);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_control_tokens();
        test_zero_stream();
        test_single_symbol();
        test_guard();
        test_pulses();
        test_mid_reset();
        test_random();
        for (int i = 0; i < 10 && due_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (due_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", due_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
